div_sequencer: RTL and testbench

Multi-cycle integer divide controller for the execute stage. It accepts one RV64M divide/remainder operation at a time from execute, runs a radix-2 restoring divider on operand magnitudes, and holds the execute stage busy until the result is handed back. The pipeline stalls on `busy`; the result is muxed into the execute stage's `alu_out` when `out_valid && out_ready`.

---
 rtl/div_sequencer.sv | 169 ++++++++++++++++
 tb/tb_div_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Brief    : Multi-cycle RV64M divide/remainder controller (radix-2 restoring).
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [6:0]  c_iterWord  = 7'd32;
   localparam logic [6:0]  c_iterDword = 7'd64;
   localparam logic [63:0] c_minNegW   = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] c_minNegD   = 64'h8000_0000_0000_0000;

   state_t      r_state;
   state_t      w_stateNext;
   logic        r_isRem;
   logic        r_isWord;
   logic        r_negQuo;
   logic        r_negRem;
   logic [63:0] r_rem;
   logic [63:0] r_quo;
   logic [63:0] r_div;
   logic [6:0]  r_count;
   logic [63:0] r_outData;

   // Operand decode, evaluated against the live inputs for the accept edge
   logic        w_isUnsigned;
   logic        w_isRem;
   logic        w_isWord;
   logic [63:0] w_opA;
   logic [63:0] w_opB;
   logic        w_signA;
   logic        w_signB;
   logic [63:0] w_magA;
   logic [63:0] w_magB;
   logic        w_divZero;
   logic        w_overflow;
   logic        w_special;
   logic [63:0] w_specialRaw;
   logic [63:0] w_specialOut;
   logic        w_accept;

   assign w_isUnsigned = in_op[0];
   assign w_isRem      = in_op[1];
   assign w_isWord     = in_op[2];

   assign w_opA = !w_isWord ? in_a :
                  (w_isUnsigned ? {32'd0, in_a[31:0]} : {{32{in_a[31]}}, in_a[31:0]});
   assign w_opB = !w_isWord ? in_b :
                  (w_isUnsigned ? {32'd0, in_b[31:0]} : {{32{in_b[31]}}, in_b[31:0]});

   assign w_signA = !w_isUnsigned && w_opA[63];
   assign w_signB = !w_isUnsigned && w_opB[63];
   assign w_magA  = w_signA ? -w_opA : w_opA;
   assign w_magB  = w_signB ? -w_opB : w_opB;

   assign w_divZero  = (w_opB == 64'd0);
   assign w_overflow = !w_isUnsigned && (&w_opB) &&
                       (w_opA == (w_isWord ? c_minNegW : c_minNegD));
   assign w_special  = w_divZero || w_overflow;

   assign w_specialRaw = w_divZero ? (w_isRem ? w_opA : {64{1'b1}})
                                   : (w_isRem ? 64'd0 : w_opA);
   assign w_specialOut = w_isWord ? {{32{w_specialRaw[31]}}, w_specialRaw[31:0]}
                                  : w_specialRaw;

   // One restoring step; the extra bit keeps the shifted remainder exact for
   // divisors above 2^63.
   logic [64:0] w_shift;
   logic        w_fits;
   logic [63:0] w_remNext;
   logic [63:0] w_quoNext;
   logic [63:0] w_quoFix;
   logic [63:0] w_remFix;
   logic [63:0] w_calcRaw;
   logic [63:0] w_calcOut;

   assign w_shift   = {r_rem, r_quo[63]};
   assign w_fits    = (w_shift >= {1'b0, r_div});
   assign w_remNext = w_fits ? (w_shift[63:0] - r_div) : w_shift[63:0];
   assign w_quoNext = {r_quo[62:0], w_fits};

   assign w_quoFix  = r_negQuo ? -w_quoNext : w_quoNext;
   assign w_remFix  = r_negRem ? -w_remNext : w_remNext;
   assign w_calcRaw = r_isRem ? w_remFix : w_quoFix;
   assign w_calcOut = r_isWord ? {{32{w_calcRaw[31]}}, w_calcRaw[31:0]} : w_calcRaw;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      in_ready    = (r_state == IDLE) && !flush;
      w_accept    = in_valid && in_ready;
      busy        = (r_state != IDLE);
      out_valid   = (r_state == DONE);
      case (r_state)
         IDLE: if (w_accept) w_stateNext = w_special ? DONE : CALC;
         CALC: if (r_count == 7'd1) w_stateNext = DONE;
         DONE: if (out_ready) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
      if (flush) begin
         w_stateNext = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_isRem   <= 1'b0;
         r_isWord  <= 1'b0;
         r_negQuo  <= 1'b0;
         r_negRem  <= 1'b0;
         r_rem     <= 64'd0;
         r_quo     <= 64'd0;
         r_div     <= 64'd0;
         r_count   <= 7'd0;
         r_outData <= 64'd0;
      end else if (w_accept) begin
         r_isRem  <= w_isRem;
         r_isWord <= w_isWord;
         r_negQuo <= w_signA ^ w_signB;
         r_negRem <= w_signA;
         r_rem    <= 64'd0;
         // W magnitudes are left-aligned so every step consumes bit 63
         r_quo    <= w_isWord ? {w_magA[31:0], 32'd0} : w_magA;
         r_div    <= w_magB;
         r_count  <= w_isWord ? c_iterWord : c_iterDword;
         if (w_special) begin
            r_outData <= w_specialOut;
         end
      end else if ((r_state == CALC) && !flush) begin
         r_rem   <= w_remNext;
         r_quo   <= w_quoNext;
         r_count <= r_count - 7'd1;
         if (r_count == 7'd1) begin
            r_outData <= w_calcOut;
         end
      end
   end

   assign out_data = r_outData;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   div_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns just after the accept edge with inputs scrambled
   task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = ~op;
      in_a     = ~a;
      in_b     = a ^ b ^ 64'h5A5A_A5A5_0F0F_F0F0;
   endtask

   task automatic waitResult(input string tag, input int expLat, input logic [63:0] expData);
      int lat = 0;
      int busyLow = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!busy) busyLow++;
      end while (!out_valid && lat < 200);
      check({tag, " latency"}, 64'(lat), 64'(expLat));
      check({tag, " data"}, out_data, expData);
      check({tag, " busy-low cycles"}, 64'(busyLow), 64'd0);
   endtask

   task automatic finishOp(input string tag);
      @(negedge clk);
      check({tag, " idle busy"}, {63'd0, busy}, 64'd0);
      check({tag, " idle out_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic runOp(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int expLat, input logic [63:0] expData);
      launch(op, a, b);
      waitResult(tag, expLat, expData);
      finishOp(tag);
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'd0;
      in_a      = 64'd0;
      in_b      = 64'd0;
      out_ready = 1'b1;
      #1;
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset out_data", out_data, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      runOp("divu 100/7", 3'b001, 64'd100, 64'd7, 65, 64'd14);
      runOp("rem -7%2", 3'b010, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
      runOp("div -7/2", 3'b000, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
      runOp("div -100/-7", 3'b000, -64'sd100, -64'sd7, 65, 64'd14);
      runOp("div 5/0", 3'b000, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      runOp("remu 5/0", 3'b011, 64'd5, 64'd0, 1, 64'd5);
      runOp("div ovf", 3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
            64'h8000_0000_0000_0000);
      runOp("divw ovf", 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
            64'hFFFF_FFFF_8000_0000);
      runOp("divuw", 3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFE);
      runOp("remw -7%3", 3'b110, -64'sd7, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFF);
      runOp("remu big", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 65,
            64'h7FFF_FFFF_FFFF_FFFE);
      runOp("divu big", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 65, 64'd1);

      // Backpressure in DONE
      out_ready = 1'b0;
      launch(3'b001, 64'd1000, 64'd10);
      waitResult("hold", 65, 64'd100);
      repeat (5) begin
         @(negedge clk);
         check("hold out_valid", {63'd0, out_valid}, 64'd1);
         check("hold out_data", out_data, 64'd100);
      end
      out_ready = 1'b1;
      finishOp("hold");

      // Flush at T+10, then a fresh op at T+11
      launch(3'b001, 64'd100, 64'd7);
      repeat (10) @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = 3'b001;
      in_a     = 64'd50;
      in_b     = 64'd5;
      #1;
      check("flush in_ready", {63'd0, in_ready}, 64'd0);
      check("flush busy before edge", {63'd0, busy}, 64'd1);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flushed busy", {63'd0, busy}, 64'd0);
      check("flushed out_valid", {63'd0, out_valid}, 64'd0);
      runOp("post-flush divu 9/3", 3'b001, 64'd9, 64'd3, 65, 64'd3);

      // Asynchronous reset mid-calculation
      launch(3'b001, 64'd100, 64'd7);
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async reset busy", {63'd0, busy}, 64'd0);
      check("async reset out_valid", {63'd0, out_valid}, 64'd0);
      check("async reset out_data", out_data, 64'd0);
      check("async reset in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      runOp("post-reset divu 77/7", 3'b001, 64'd77, 64'd7, 65, 64'd11);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
`default_nettype wire
